add_serial_feeder: RTL and testbench
====================================

# add_serial_feeder

Operand sequencer and result collector wrapped around one `add_serial` instance. Accepts 8-bit operand pairs over a valid/ready handshake into a small FIFO, launches one serial add at a time via a single-cycle enable, and holds the operands stable for the whole bit-serial pass. It captures the 8-bit sum after a fixed latency, derives carry-out locally, and presents sum and carry on a valid/ready result port.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, at least 2.
- `ADD_LAT`, 10: cycles from the `add_en` cycle to the `add_out` capture; covers 1 load + 8 ADD + 1 margin.
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  FIFO not full.
- `in_a`  in  8  operand A.
- `in_b`  in  8  operand B.
- `add_en`  out  1  one-cycle start pulse to the adder.
- `add_a`  out  8  operand A to the adder; held for the whole job.
- `add_b`  out  8  operand B to the adder; held for the whole job.
- `add_out`  in  8  adder parallel result.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_sum`  out  8  captured sum, `(a+b) mod 256`.
- `res_carry`  out  1  carry-out of `a+b`.

## Operation
- Input push: `in_valid && in_ready` writes `{in_a,in_b}` to the FIFO.
- FSM states: `S_IDLE`, `S_START`, `S_WAIT`, `S_GAP`.
- `S_IDLE`:
  - Requires FIFO non-empty and an output register that is free: `!res_valid`, or `res_ready` asserted this cycle.
  - When both hold: pop the head into `a_hold`/`b_hold` and go to `S_START`.
- `S_START`: `add_en=1` for exactly this cycle. Load `wait_cnt=ADD_LAT-1`, go to `S_WAIT`.
- `S_WAIT`:
  - Decrement `wait_cnt` each cycle.
  - At 0: `res_sum<=add_out`, `res_carry<=(add_out<a_hold)`, `res_valid<=1`, go to `S_GAP`.
- `S_GAP`: one cycle with `add_en=0` so the adder returns to idle, then `S_IDLE`.
- `add_a`/`add_b` always equal `a_hold`/`b_hold`. These change only on pop.
- Result handshake:
  - `res_valid` clears on `res_valid && res_ready` unless a new capture occurs in the same cycle.
  - A new capture always sets `res_valid`.
  - `res_sum` and `res_carry` are stable while `res_valid && !res_ready`.
- FIFO: `DEPTH` entries, pointers one bit wider than the index.
  - Full when the MSBs differ and the index bits are equal. Empty when the pointers are equal.
  - Pointers wrap silently.
  - Push and pop in the same cycle when full: allowed only if the pop is registered first. `in_ready` is the registered not-full flag, so no push is accepted while full.
- Carry rule: unsigned 8-bit compare. Example: 0xFF+0x01 gives sum 0x00, carry 1.

## Timing
- Reset values:
  - Outputs: `in_ready=1`, `add_en=0`, `add_a=0`, `add_b=0`, `res_valid=0`, `res_sum=0`, `res_carry=0`.
  - Internal: FSM `S_IDLE`, FIFO empty, `wait_cnt=0`.
- Latency with an empty FIFO and a free output:
  - Push at cycle T.
  - Pop at T+1 (FIFO write visible next cycle).
  - `add_en` at T+2.
  - Capture at T+2+`ADD_LAT`; `res_valid` high from T+3+`ADD_LAT`.
- Throughput: one job per `ADD_LAT`+3 cycles with `res_ready` held high.
- Back-to-back jobs always have at least one `add_en=0` cycle (`S_GAP`) between pulses.
- Backpressure: `res_valid` held with `res_ready=0` blocks the next pop. The FIFO fills and `in_ready` drops after `DEPTH` pushes.
- Reset asserted mid-job:
  - All state clears asynchronously; the FIFO contents are discarded.
  - `add_en` goes low immediately.
  - No stale result appears after reset release.

## Structure
- Package `add_serial_pkg`: FSM state enum (2-bit), `DATA_W=8`, default `ADD_LAT`.
- Sub-module `feeder_fifo`: parameterised synchronous FIFO (`DEPTH`, width 16), async active-high reset, with registered full/empty outputs.
- Top level: FSM, wait counter, hold registers, result register, carry compare.

## Test plan
- Single job: push A=0x35, B=0x4A. One `add_en` pulse appears, `add_a`/`add_b` stay stable through capture, then `res_sum=0x7F`, `res_carry=0`, with `res_valid` at the latency given above.
- Overflow: A=0xFF, B=0x01 gives `res_sum=0x00`, `res_carry=1`. A=0x80, B=0x80 gives 0x00, carry 1.
- FIFO fill: with `res_ready=0`, push 6 pairs. Exactly `DEPTH`+1 pairs are accepted (4 in the FIFO, 1 in hold) and `in_ready` goes 0. Then release `res_ready`: all results come out in order with correct sums, and `add_en` pulses are never adjacent.
- Pointer wrap-around: stream 20 random pairs with random `res_ready`. The scoreboard matches every sum and carry in order, with no loss or duplication.
- Reset mid-job: assert `rst` 5 cycles after `add_en`. Outputs return to their reset values immediately, and after release `res_valid` stays 0 until a new push completes.
- Simultaneous events: `res_ready` is high in the same cycle the FSM is in `S_IDLE` with the FIFO non-empty. The pop proceeds that cycle and the old result is consumed exactly once.

Source files
------------

// File: rtl/add_serial_pkg.sv
// Shared types and constants for the serial-adder feeder.
package add_serial_pkg;

   localparam int DATA_W      = 8;
   localparam int ADD_LAT_DEF = 10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_GAP   = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/add_serial_feeder_fifo.sv
// Operand FIFO with registered full/empty flags; pointers carry one extra wrap bit.
module feeder_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [AW:0]  wr_nxt;
   logic [AW:0]  rd_nxt;
   logic         do_push;
   logic         do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign wr_nxt  = wr_ptr + {{AW{1'b0}}, do_push};
   assign rd_nxt  = rd_ptr + {{AW{1'b0}}, do_pop};
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         // flags are computed from the next pointers so they are registered, not combinational
         full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
         empty  <= (wr_nxt == rd_nxt);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/add_serial_feeder.sv
// Feeds operand pairs to one add_serial instance and collects sum/carry results.
//
//  state   | meaning
//  S_IDLE  | wait for a queued pair and a free result register, then pop
//  S_START | single-cycle add_en pulse, load latency counter
//  S_WAIT  | adder running; capture add_out when the counter reaches 0
//  S_GAP   | one add_en=0 cycle so the adder returns to idle
module add_serial_feeder
   import add_serial_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ADD_LAT = ADD_LAT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              add_en,
   output logic [DATA_W-1:0] add_a,
   output logic [DATA_W-1:0] add_b,
   input  logic [DATA_W-1:0] add_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_sum,
   output logic              res_carry
);

   localparam int CW = $clog2(ADD_LAT + 1);

   feeder_state_t     state;
   feeder_state_t     state_nxt;
   logic [CW-1:0]     wait_cnt;
   logic [DATA_W-1:0] a_hold;
   logic [DATA_W-1:0] b_hold;
   logic [2*DATA_W-1:0] fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic              cnt_load;
   logic              capture;

   feeder_fifo #(
      .DEPTH (DEPTH),
      .W     (2 * DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .wdata ({in_a, in_b}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign in_ready = !fifo_full;
   assign add_a    = a_hold;
   assign add_b    = b_hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      cnt_load  = 1'b0;
      capture   = 1'b0;
      add_en    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty && (!res_valid || res_ready)) begin
               fifo_pop  = 1'b1;
               state_nxt = S_START;
            end
         end
         S_START: begin
            add_en    = 1'b1;
            cnt_load  = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt == '0) begin
               capture   = 1'b1;
               state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (cnt_load) begin
         wait_cnt <= CW'(ADD_LAT - 1);
      end else if (state == S_WAIT && wait_cnt != '0) begin
         wait_cnt <= wait_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_hold <= '0;
         b_hold <= '0;
      end else if (fifo_pop) begin
         a_hold <= fifo_rdata[2*DATA_W-1:DATA_W];
         b_hold <= fifo_rdata[DATA_W-1:0];
      end
   end

   // a wrapped sum is smaller than either operand, which gives the carry without a 9-bit add
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_carry <= 1'b0;
      end else if (capture) begin
         res_valid <= 1'b1;
         res_sum   <= add_out;
         res_carry <= (add_out < a_hold);
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_add_serial_feeder.sv
// Bench for add_serial_feeder: bit-serial adder model, operand/result scoreboard, directed scenarios.
module tb_add_serial_feeder;
   import add_serial_pkg::*;

   localparam int DEPTH   = 4;
   localparam int ADD_LAT = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_a = 8'h00;
   logic [7:0] in_b = 8'h00;
   logic       add_en;
   logic [7:0] add_a;
   logic [7:0] add_b;
   logic [7:0] add_out;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [7:0] res_sum;
   logic       res_carry;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] job_q [$];
   logic [8:0]  exp_q [$];

   add_serial_feeder #(.DEPTH(DEPTH), .ADD_LAT(ADD_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .add_en    (add_en),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_out   (add_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_carry (res_carry)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // serial adder model: load on add_en, then one sum bit per cycle, LSB first
   logic [7:0] m_a, m_b, m_acc;
   logic       m_c, m_busy;
   logic [2:0] m_bit;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_a <= '0; m_b <= '0; m_acc <= '0; m_c <= 1'b0; m_busy <= 1'b0; m_bit <= '0;
      end else if (add_en) begin
         m_a <= add_a; m_b <= add_b; m_acc <= '0; m_c <= 1'b0; m_busy <= 1'b1; m_bit <= '0;
      end else if (m_busy) begin
         m_acc <= {m_a[m_bit] ^ m_b[m_bit] ^ m_c, m_acc[7:1]};
         m_c   <= (m_a[m_bit] & m_b[m_bit]) | (m_c & (m_a[m_bit] ^ m_b[m_bit]));
         m_bit <= m_bit + 3'd1;
         if (m_bit == 3'd7) m_busy <= 1'b0;
      end
   end
   assign add_out = m_acc;

   // monitor: pushes expectations on accepted pairs, checks launches, hold and results
   initial begin
      logic [15:0] cur;
      logic [8:0]  e;
      logic        prev_en;
      int          hold_left;
      cur = '0; prev_en = 1'b0; hold_left = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            job_q.delete(); exp_q.delete(); prev_en = 1'b0; hold_left = 0;
         end else begin
            if (in_valid && in_ready) begin
               job_q.push_back({in_a, in_b});
               exp_q.push_back(9'(in_a) + 9'(in_b));
            end
            if (add_en) begin
               chk("en_gap", {31'd0, prev_en}, 0);
               if (job_q.size() == 0) chk("en_spurious", {31'd0, add_en}, 0);
               else begin
                  cur = job_q.pop_front();
                  chk("add_ops", {16'd0, add_a, add_b}, {16'd0, cur});
                  hold_left = ADD_LAT;
               end
            end else if (hold_left > 0) begin
               chk("hold_ops", {16'd0, add_a, add_b}, {16'd0, cur});
               hold_left--;
            end
            prev_en = add_en;
            if (res_valid && res_ready) begin
               if (exp_q.size() == 0) chk("res_spurious", {31'd0, res_valid}, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("res", {23'd0, res_carry, res_sum}, {23'd0, e});
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [7:0] a, input logic [7:0] b);
      int k;
      k = 0;
      in_valid = 1'b1; in_a = a; in_b = b;
      while (!in_ready && k < 200) begin tick(); k++; end
      if (k == 200) chk("push_timeout", {31'd0, in_ready}, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain(input int bound);
      int k;
      k = 0;
      res_ready = 1'b1;
      while (exp_q.size() != 0 && k < bound) begin tick(); k++; end
      repeat (3) tick();
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      int  k, acc, sent;
      logic took, seen;

      #3;
      chk("rst_outputs", {13'd0, in_ready, add_en, add_a, add_b, res_valid, res_sum, res_carry},
          {13'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0});
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // single job with latency checks
      res_ready = 1'b1;
      in_valid = 1'b1; in_a = 8'h35; in_b = 8'h4A;
      tick();
      in_valid = 1'b0;
      k = 1;
      while (!add_en && k < 50) begin tick(); k++; end
      chk("lat_en", k, 2);
      while (!res_valid && k < 100) begin tick(); k++; end
      chk("lat_res", k, 3 + ADD_LAT);
      chk("single_sum", {23'd0, res_carry, res_sum}, {23'd0, 9'h07F});
      drain(100);

      // overflow cases
      push_one(8'hFF, 8'h01);
      push_one(8'h80, 8'h80);
      drain(200);

      // FIFO fill under backpressure
      res_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 40; c++) begin
         in_valid = (acc < 6);
         in_a = 8'(16 * acc + 3);
         in_b = 8'(200 + 11 * acc);
         @(negedge clk);
         took = in_valid && in_ready;
         tick();
         if (took) acc++;
      end
      in_valid = 1'b0;
      chk("fill_accepted", acc, DEPTH + 1);
      chk("fill_in_ready", {31'd0, in_ready}, 0);
      chk("fill_res_valid", {31'd0, res_valid}, 1);
      drain(500);

      // random stream, exercises pointer wrap
      sent = 0;
      for (int c = 0; c < 3000 && sent < 20; c++) begin
         res_ready = 1'($urandom_range(0, 1));
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_a = 8'($urandom);
            in_b = 8'($urandom);
         end
         @(negedge clk);
         took = in_valid && in_ready;
         tick();
         if (took) begin sent++; in_valid = 1'b0; end
      end
      in_valid = 1'b0;
      chk("rand_sent", sent, 20);
      drain(1000);

      // result handshake coincides with a pop
      res_ready = 1'b0;
      push_one(8'h11, 8'h22);
      push_one(8'hC0, 8'h50);
      repeat (30) tick();
      chk("simul_pre_valid", {31'd0, res_valid}, 1);
      res_ready = 1'b1;
      @(negedge clk);
      tick();
      res_ready = 1'b0;
      chk("simul_en", {31'd0, add_en}, 1);
      chk("simul_valid", {31'd0, res_valid}, 0);
      chk("simul_q", exp_q.size(), 1);
      drain(200);

      // reset mid-job
      res_ready = 1'b1;
      push_one(8'h5A, 8'h33);
      k = 0;
      while (!add_en && k < 50) begin tick(); k++; end
      chk("rst_job_en", {31'd0, add_en}, 1);
      repeat (5) tick();
      rst = 1'b1;
      #1;
      chk("rst_mid_outputs", {13'd0, in_ready, add_en, add_a, add_b, res_valid, res_sum, res_carry},
          {13'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0});
      repeat (2) tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin tick(); seen = seen | res_valid | add_en; end
      chk("rst_no_stale", {31'd0, seen}, 0);
      push_one(8'h12, 8'h34);
      drain(200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
